// File: rtl/pla_decode_sequencer.sv
// Sequences the combinational opcode PLA decoder: registered x-drive, settle wait, capture into output FIFO.
// Optional macro PLA_RESERVED_CHECK_EN adds sticky reserved_err for nonzero reserved outputs z[68:61].
module pla_decode_sequencer #(
    parameter int IN_W   = 17,
    parameter int OUT_W  = 69,
    parameter int SETTLE = 1,
    parameter int DEPTH  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic [IN_W-1:0]  pla_x,
    input  logic [OUT_W-1:0] pla_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_ctrl,
    output logic             out_illegal,
    output logic             busy
`ifdef PLA_RESERVED_CHECK_EN
    ,
    output logic             reserved_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;

    localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IN_W-1:0]  pla_x_q, pla_x_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W:0]   mem_q [DEPTH];
    logic [OUT_W:0]   head;
    logic             push;
    logic             pop;

    // Sequencer: one word in flight; acceptance gated on a free FIFO slot so CAP never overflows.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pla_x_d  = pla_x_q;
        push     = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = (count_q < DEPTH_C);
                if (in_valid && in_ready) begin
                    pla_x_d = in_data;
                    cnt_d   = SETTLE_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAP: begin
                push    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            pla_x_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pla_x_q  <= pla_x_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {~|pla_z, pla_z};
        end
    end

    assign pla_x       = pla_x_q;
    assign out_ctrl    = out_valid ? head[OUT_W-1:0] : '0;
    assign out_illegal = out_valid & head[OUT_W];
    assign busy        = (state_q != S_IDLE) || out_valid;

`ifdef PLA_RESERVED_CHECK_EN
    logic reserved_err_q, reserved_err_d;

    always_comb begin
        reserved_err_d = reserved_err_q | (push & (|pla_z[OUT_W-1 -: 8]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reserved_err_q <= 1'b0;
        end else begin
            reserved_err_q <= reserved_err_d;
        end
    end

    assign reserved_err = reserved_err_q;
`endif

endmodule

// File: doc/pla_decode_sequencer.md
Name: pla_decode_sequencer

Overview:
- Sequences the combinational opcode PLA decoder (17-bit x-vector in, 69-bit z-vector out).
- Accepts opcode words over a valid/ready handshake and drives the decoder from a register.
- Waits a programmable settle time, captures the decoded control word and queues it in a small output FIFO for the execute stage.
- Flags words that decode to no asserted control line as illegal.

Parameters:
- IN_W, 17, opcode/decoder input width; bit i drives decoder input xNN, NN = i.
- OUT_W, 69, decoder output width; bit i is decoder output zNN, NN = i.
- SETTLE, 1, cycles the decoder input is held before capture; legal range 1..15.
- DEPTH, 2, output FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  opcode word offered
- in_ready  out  1  sequencer accepts the word this cycle
- in_data  in  IN_W  opcode word
- pla_x  out  IN_W  registered drive to the decoder inputs
- pla_z  in  OUT_W  decoder outputs (combinational from pla_x)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes the head
- out_ctrl  out  OUT_W  decoded control word at the FIFO head
- out_illegal  out  1  head word had pla_z == 0
- busy  out  1  state != IDLE or FIFO not empty

Behaviour:
- Reset values (async, rst=1):
  - pla_x = 0 and state = IDLE.
  - FIFO is empty: out_valid=0, out_ctrl=0, out_illegal=0.
  - busy=0 and the settle counter is 0.
- FSM states:
  - IDLE: in_ready = (count < DEPTH). On in_valid & in_ready, pla_x <= in_data, cnt <= SETTLE-1, go to WAIT.
  - WAIT: in_ready=0. Hold pla_x. If cnt==0, go to CAP; else cnt--.
  - CAP: in_ready=0. Push {pla_z==0, pla_z} into the FIFO, go to IDLE.
- Only one word is in flight at a time. Acceptance requires a free FIFO slot, so the CAP push never sees a full FIFO; no overflow path exists.
- Latency: handshake at cycle N gives pla_x valid at N+1, the push at N+1+SETTLE, and out_valid at N+2+SETTLE (N+3 for SETTLE=1).
- Throughput: one word per SETTLE+2 cycles.
- pla_x keeps its last value in IDLE; it is not cleared after capture.
- FIFO:
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - out_ctrl and out_illegal are driven from the head entry. When the FIFO is empty they read 0.
- A FIFO pop in the same cycle as an IDLE acceptance check: in_ready uses the count from before the pop (registered count, no combinational ready-from-ready path).
- in_data is sampled only on the handshake cycle. Changes to in_valid or in_data during WAIT/CAP are ignored.
- Reset mid-operation (any state): the in-flight word is discarded, the FIFO is flushed and all outputs return to their reset values immediately.

Optional Feature:
- Macro PLA_RESERVED_CHECK_EN adds a sticky error output `reserved_err` (1 bit).
  - In CAP it sets if pla_z[68:61] != 0; these decoder outputs are reserved and must be constant zero.
  - It clears only on rst.
  - An offending word is still pushed, with its out_illegal computed normally.
- Without the macro: no `reserved_err` port and no check logic; pla_z[68:61] is passed through into out_ctrl unchanged.

Test Plan:
- Reset then single word, SETTLE=1: in_data=17'h0003C handshake at cycle 0 -> pla_x=17'h0003C at cycle 1, out_valid=1 at cycle 3, out_ctrl equals the decoder model output (bit 3 set), out_illegal=0.
- Illegal decode: in_data=17'h00001 (x00=1, the decoder drives all zero) -> out_ctrl=0, out_illegal=1, out_valid=1.
- Backpressure: out_ready=0, offer 3 back-to-back words with DEPTH=2 -> first two captured, in_ready=0 while count==2. Raise out_ready one cycle -> third word accepted the following cycle. Outputs drain in order.
- Settle timing: SETTLE=4 -> push at cycle 5, out_valid at cycle 6. in_ready is low for cycles 1-5 and in_data changes during WAIT do not affect pla_x.
- Async reset at the WAIT cycle with one FIFO entry held -> out_valid, busy and pla_x drop to 0 without a clock edge; after release the next word completes with nominal latency.
- PLA_RESERVED_CHECK_EN defined: force pla_z[61]=1 in CAP -> reserved_err=1 and stays set across later clean words until rst.
